if_id_stage_ctrl: RTL
=====================

// Module: if_id_stage_ctrl
// PURPOSE
//  Controls the IF/ID boundary of the pipelined core. Holds fetched instructions in a small buffer
//  and presents one at a time to decode (imm_gen, register file, control).
//  Inserts a bubble on a load-use hazard against EX. Discards all buffered instructions on a
//  redirect: taken branch, JAL/JALR, trap entry or MRET from CSR. Counts bubble cycles for perf CSRs.
// PARAMETERS
//  XLEN   32  data/PC width
//  DEPTH  2   buffer entries; power of two, >=2
// PORTS
//  clk          in   1     core clock, rising edge
//  rst_n        in   1     asynchronous active-low reset
//  f_valid      in   1     fetch offers instruction this cycle
//  f_inst       in   32    fetched instruction word
//  f_pc         in   XLEN  PC of f_inst
//  f_ready      out  1     buffer accepts an instruction this cycle
//  d_valid      out  1     decode slot holds an instruction to be issued
//  d_inst       out  32    head instruction (drives imm_gen/decoder)
//  d_pc         out  XLEN  PC of head instruction
//  d_ready      in   1     downstream (ID/EX) accepts d_inst this cycle
//  ex_load      in   1     instruction in EX is a load (opcode 0000011)
//  ex_rd        in   5     destination register of EX instruction
//  flush        in   1     redirect: drop everything buffered and in flight
//  bubble       out  1     1 when head is held by a load-use hazard this cycle
//  bubble_cnt   out  32    saturating count of bubble cycles
// BEHAVIOUR
//  - Reset (rst_n=0, async): count=0, rd/wr pointers=0, bubble_cnt=0.
//    Outputs during reset: d_valid=0, bubble=0, f_ready=0.
//    d_inst/d_pc=0 while empty.
//  - Storage is a DEPTH-entry circular FIFO of {inst,pc}.
//    count is 0..DEPTH; pointers wrap modulo DEPTH.
//  - f_ready = rst_n & (count != DEPTH). It depends on count only, never on d_ready.
//  - push = f_valid & f_ready & ~flush.
//  - There is no empty bypass: an instruction pushed in cycle N is visible on d_* from cycle N+1.
//  - hazard = count!=0 & ex_load & ex_rd!=0 & ((uses_rs1 & rs1==ex_rd) | (uses_rs2 & rs2==ex_rd)).
//    rs1 = d_inst[19:15]; rs2 = d_inst[24:20].
//    uses_rs1: opcode not in {0110111 LUI, 0010111 AUIPC, 1101111 JAL}.
//    uses_rs2: opcode in {0110011 R, 0100011 S, 1100011 B}.
//  - d_valid = (count!=0) & ~hazard & ~flush.
//  - bubble = (count!=0) & hazard & ~flush.
//  - pop = d_valid & d_ready.
//  - Count update: push only -> +1. pop only -> -1. push & pop -> unchanged.
//    When full, pop frees a slot, but f_ready rises only in the next cycle.
//  - flush (synchronous, highest priority): next count=0 and rd_ptr=wr_ptr.
//    The same-cycle f_valid instruction is dropped, and d_valid=0 that cycle.
//    flush while empty has no effect beyond this.
//  - A hazard stall holds the head; ex_* is re-evaluated every cycle.
//    The buffer may still fill behind the head.
//  - bubble_cnt increments by 1 each cycle bubble=1 and saturates at 32'hFFFF_FFFF.
//    flush does not clear it.
//  - d_inst/d_pc remain stable while d_valid=1 & d_ready=0.
//  - Reset asserted mid-operation discards all entries immediately.
//    The first push after reset release appears at d_* one cycle later.
// TESTING
//  1 Streaming: f_valid=1 with insts A,B,C on cycles 0..2, d_ready=1.
//    -> d_inst=A,B,C on cycles 1..3; f_ready stays 1; count never exceeds 1.
//  2 Backpressure: d_ready=0, push A,B.
//    -> f_ready=0 on cycle 2; d_inst holds A. Raise d_ready on cycle 4 -> A pops, f_ready=1 cycle 5.
//  3 Load-use: head "add x3,x5,x6" with ex_load=1, ex_rd=5.
//    -> d_valid=0, bubble=1, bubble_cnt +1. Next cycle ex_load=0 -> d_valid=1.
//  4 No false hazard: head "lui x5,0x12345", or ex_rd=0 with rs1=0, ex_load=1.
//    -> d_valid=1, bubble=0.
//  5 Flush: buffer full (A,B), flush=1 with f_valid=1 carrying C.
//    -> next cycle count=0, d_valid=0, C never issued, f_ready=1.
//  6 Reset mid-stream: drop rst_n asynchronously while count=2.
//    -> d_valid=0, bubble_cnt=0 immediately. After release, push D -> d_inst=D one cycle later.

Source files
------------

// File: rtl/if_id_stage_ctrl.sv
// IF/ID boundary controller: small instruction FIFO feeding decode, load-use bubble
// insertion against EX, redirect flush, and a saturating bubble-cycle counter.
module if_id_stage_ctrl #(
   parameter int XLEN  = 32,
   parameter int DEPTH = 2
) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic            f_valid,
   input  logic [31:0]     f_inst,
   input  logic [XLEN-1:0] f_pc,
   output logic            f_ready,
   output logic            d_valid,
   output logic [31:0]     d_inst,
   output logic [XLEN-1:0] d_pc,
   input  logic            d_ready,
   input  logic            ex_load,
   input  logic [4:0]      ex_rd,
   input  logic            flush,
   output logic            bubble,
   output logic [31:0]     bubble_cnt
);
   localparam int PW = $clog2(DEPTH);
   localparam logic [PW:0]   FULL    = (PW+1)'(DEPTH);
   localparam logic [PW:0]   CNT_ONE = (PW+1)'(1);
   localparam logic [PW-1:0] PTR_ONE = PW'(1);

   logic [31:0]     r_inst [DEPTH];
   logic [XLEN-1:0] r_pc   [DEPTH];
   logic [PW-1:0]   r_rd_ptr;
   logic [PW-1:0]   r_wr_ptr;
   logic [PW:0]     r_count;
   logic [31:0]     r_bubble_cnt;

   logic            w_empty;
   logic [31:0]     w_head_inst;
   logic [6:0]      w_opcode;
   logic            w_uses_rs1;
   logic            w_uses_rs2;
   logic            w_hazard;
   logic            w_push;
   logic            w_pop;

   assign w_empty     = (r_count == '0);
   assign w_head_inst = r_inst[r_rd_ptr];
   assign w_opcode    = w_head_inst[6:0];

   // LUI/AUIPC/JAL carry immediate bits in the rs1 field; only R/S/B read rs2.
   assign w_uses_rs1 = !(w_opcode inside {7'b0110111, 7'b0010111, 7'b1101111});
   assign w_uses_rs2 = w_opcode inside {7'b0110011, 7'b0100011, 7'b1100011};

   assign w_hazard = !w_empty && ex_load && (ex_rd != 5'd0) &&
                     ((w_uses_rs1 && (w_head_inst[19:15] == ex_rd)) ||
                      (w_uses_rs2 && (w_head_inst[24:20] == ex_rd)));

   // f_ready looks at occupancy only, so a pop from full frees the slot a cycle later.
   assign f_ready = rst_n && (r_count != FULL);
   assign w_push  = f_valid && f_ready && !flush;
   assign d_valid = !w_empty && !w_hazard && !flush;
   assign bubble  = !w_empty && w_hazard && !flush;
   assign w_pop   = d_valid && d_ready;

   assign d_inst     = w_empty ? '0 : w_head_inst;
   assign d_pc       = w_empty ? '0 : r_pc[r_rd_ptr];
   assign bubble_cnt = r_bubble_cnt;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_rd_ptr <= '0;
         r_wr_ptr <= '0;
         r_count  <= '0;
      end else if (flush) begin
         r_rd_ptr <= r_wr_ptr;
         r_count  <= '0;
      end else begin
         if (w_push) r_wr_ptr <= r_wr_ptr + PTR_ONE;
         if (w_pop)  r_rd_ptr <= r_rd_ptr + PTR_ONE;
         case ({w_push, w_pop})
            2'b10:   r_count <= r_count + CNT_ONE;
            2'b01:   r_count <= r_count - CNT_ONE;
            default: r_count <= r_count;
         endcase
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_bubble_cnt <= '0;
      end else if (bubble && (r_bubble_cnt != 32'hFFFF_FFFF)) begin
         r_bubble_cnt <= r_bubble_cnt + 32'd1;
      end
   end

   // Payload storage needs no reset: entries are only read while count is non-zero.
   always_ff @(posedge clk) begin
      if (w_push) begin
         r_inst[r_wr_ptr] <= f_inst;
         r_pc[r_wr_ptr]   <= f_pc;
      end
   end

endmodule
